// File: rtl/rcu.sv
// rtl/rcu.sv - receiver control unit: first word of a session is the cipher key, following words are data blocks
// Optional build macro RCU_KEY_LOCK_EN: capture the key only once after reset.
module rcu (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         read,
    input  logic [128:0] data_in,
    output logic [127:0] key,
    output logic [128:0] data,
    output logic         r_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   load_key;
    logic   load_data;

`ifdef RCU_KEY_LOCK_EN
    // Set by the first key capture; keeps later sessions from replacing the key.
    logic key_locked;

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            key_locked <= 1'b0;
        end else if (load_key) begin
            key_locked <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_key  = 1'b0;
        load_data = 1'b0;
        case (state)
            IDLE: begin
                if (read) begin
`ifdef RCU_KEY_LOCK_EN
                    if (key_locked) begin
                        load_data = 1'b1;
                        state_nxt = DATA;
                    end else begin
                        load_key  = 1'b1;
                        state_nxt = KEY;
                    end
`else
                    load_key  = 1'b1;
                    state_nxt = KEY;
`endif
                end
            end
            KEY: begin
                if (read) begin
                    load_data = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (read) begin
                    load_data = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers only move on a capture; r_ready marks each data capture.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            key     <= 128'h0;
            data    <= 129'h0;
            r_ready <= 1'b0;
        end else begin
            if (load_key) begin
                key <= data_in[127:0];
            end
            if (load_data) begin
                data <= data_in;
            end
            r_ready <= load_data;
        end
    end

endmodule

// File: tb/tb_rcu.sv
// tb/tb_rcu.sv - scoreboard bench for rcu with directed and random stimulus
module tb_rcu;

    logic         tb_clk;
    logic         n_rst;
    logic         read;
    logic [128:0] data_in;
    logic [127:0] key;
    logic [128:0] data;
    logic         r_ready;

    rcu dut (
        .clk     (tb_clk),
        .n_rst   (n_rst),
        .read    (read),
        .data_in (data_in),
        .key     (key),
        .data    (data),
        .r_ready (r_ready)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic [127:0] key;
        logic [128:0] data;
        logic         r_ready;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

`ifdef RCU_KEY_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    // Reference model: session bookkeeping
    logic [127:0] m_key;
    logic [128:0] m_data;
    bit           m_in_session;   // a key (or locked key) is in force for the current burst
    bit           m_got_data;     // at least one data block seen in the current session
    bit           m_key_taken;    // a key was captured since reset

    task automatic model_reset();
        m_key        = '0;
        m_data       = '0;
        m_in_session = 0;
        m_got_data   = 0;
        m_key_taken  = 0;
    endtask

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // One host cycle: drive inputs, predict post-edge outputs, queue prediction
    task automatic step(input logic r, input logic [128:0] d);
        exp_t e;
        bit   rr;
        @(negedge tb_clk);
        #1;
        read    = r;
        data_in = d;
        rr      = 0;
        if (r) begin
            if (!m_in_session && !(LOCK && m_key_taken)) begin
                m_key        = d[127:0];
                m_key_taken  = 1;
                m_in_session = 1;
                m_got_data   = 0;
            end else begin
                m_data       = d;
                m_in_session = 1;
                m_got_data   = 1;
                rr           = 1;
            end
        end else if (m_got_data) begin
            m_in_session = 0;
            m_got_data   = 0;
        end
        e.key     = m_key;
        e.data    = m_data;
        e.r_ready = rr;
        sb.push_back(e);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
    task automatic do_reset();
        @(negedge tb_clk);
        #1;
        read = 1'b0;
        #1;
        n_rst = 1'b1;
        #1;
        check("rst_key", {1'b0, key}, 129'h0);
        check("rst_data", data, 129'h0);
        check("rst_r_ready", {128'h0, r_ready}, 129'h0);
        model_reset();
        @(posedge tb_clk);
        #2;
        n_rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge tb_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("key", {1'b0, key}, {1'b0, e.key});
                check("data", data, e.data);
                check("r_ready", {128'h0, r_ready}, {128'h0, e.r_ready});
            end
        end
    end

    function automatic logic [128:0] rnd_word();
        logic [128:0] w;
        w = {$urandom_range(0, 1) == 1, $urandom(), $urandom(), $urandom(), $urandom()};
        return w;
    endfunction

    initial begin : driver
        logic [128:0] w;
        int           wait_cycles;
        n_rst   = 1'b0;
        read    = 1'b0;
        data_in = '0;
        model_reset();
        do_reset();

        // Directed: key, data, back-to-back, end of burst, restart
        step(1'b1, {1'b0, 128'h00112233445566778899AABBCCDDEEFF});
        step(1'b1, {1'b0, 128'hA0B0C566D0F6F0A0C0E0E0F0A0B0D0E0});
        step(1'b1, {1'b0, 128'h4278b840fb44aaa757c1bf04acbe1a3e});
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b1, {1'b0, 128'hFFEEDDCCBBAA99887766554433221100});
        step(1'b0, '0);

        // KEY hold, with bit 128 set on the key word to show it is dropped
        do_reset();
        step(1'b1, {1'b1, 128'h0123456789ABCDEF0123456789ABCDEF});
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b1, {1'b1, 128'hDEADBEEFCAFEF00D1122334455667788});
        step(1'b0, '0);

        // Reset mid-burst, then the next word must be a key
        step(1'b1, {1'b0, 128'h1});
        step(1'b1, {1'b0, 128'h2});
        do_reset();
        step(1'b1, {1'b1, 128'h5555AAAA5555AAAA5555AAAA5555AAAA});
        step(1'b1, {1'b1, 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F});
        step(1'b0, '0);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            w = rnd_word();
            step($urandom_range(0, 2) != 0, w);
        end
        step(1'b0, '0);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(negedge tb_clk);
            wait_cycles++;
        end
        #2;
        check("scoreboard_drained", 129'(sb.size()), 129'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rcu.md
# rcu

Receiver control unit at the input side of the cryptographic module. It accepts 129-bit words from the host interface under a `read` strobe. The first word of a session is captured as the 128-bit cipher key. Each following word is captured as a 129-bit data block and flagged with `r_ready` for the downstream cipher core.

## Interface
- No parameters. Widths are fixed: key 128 bits, data word 129 bits.
- `clk` input 1 — single system clock; all state updates on its rising edge.
- `n_rst` input 1 — reset, asynchronous and active-high (asserted when 1, despite the name). Forces all registers to reset values immediately.
- `read` input 1 — host strobe; `data_in` is valid and is consumed on every rising edge where `read`=1.
- `data_in` input 129 — incoming word; bits [127:0] carry the key in a key word; all 129 bits carry a data word.
- `key` output 128 — registered cipher key.
- `data` output 129 — registered most recent data block.
- `r_ready` output 1 — registered; 1 on the cycle after a data block was captured.

## Operation
- FSM states: IDLE, KEY, DATA. Reset state is IDLE.
- IDLE, `read`=1: `key` <= `data_in[127:0]`; go to KEY; `r_ready` <= 0. `data_in[128]` is ignored for key words.
- IDLE, `read`=0: hold; `r_ready` <= 0.
- KEY, `read`=1: `data` <= `data_in`; go to DATA; `r_ready` <= 1.
- KEY, `read`=0: stay in KEY; `r_ready` <= 0; key held.
- DATA, `read`=1: `data` <= `data_in`; stay in DATA; `r_ready` <= 1. This supports back-to-back blocks, one per cycle.
- DATA, `read`=0: go to IDLE; `r_ready` <= 0. `data` and `key` hold their values.
- `key` changes only on a key capture; `data` changes only on a data capture; neither is ever cleared except by reset.
- Reset mid-operation, in any state: `key`=0, `data`=0, `r_ready`=0, state=IDLE. The next `read` is treated as a key word.

## Timing
- Reset values: `key`=128'h0, `data`=129'h0, `r_ready`=0.
- Latency: a word sampled at rising edge N appears on `key`/`data` immediately after edge N. `r_ready` reflects that capture in the same post-edge cycle.
- `r_ready` is high for exactly one cycle per captured data block. It stays continuously high while `read` is held high in KEY/DATA.
- No backpressure: every `read`=1 cycle consumes a word; the host must not assert `read` without valid data.
- All outputs come straight from flops; no combinational input-to-output paths.

## Configuration
- `RCU_KEY_LOCK_EN` defined: a key is captured only once after reset. When IDLE is re-entered from DATA and `read`=1, the word is captured as data: `data` <= `data_in`, go to DATA, `r_ready` <= 1. `key` is unchanged until the next reset.
- `RCU_KEY_LOCK_EN` undefined: every IDLE→`read` transition captures a fresh key, as described in Operation.

## Test plan
- Reset: assert `n_rst`=1 asynchronously mid-cycle -> `key`=0, `data`=0, `r_ready`=0 immediately; state IDLE.
- Key capture: `read`=1, `data_in`=129'h0_00112233445566778899AABBCCDDEEFF -> next cycle `key`=128'h00112233445566778899AABBCCDDEEFF, `r_ready`=0.
- Data capture: keep `read`=1, `data_in`=129'h0_A0B0C566D0F6F0A0C0E0E0F0A0B0D0E0 -> next cycle `data`=that value, `r_ready`=1.
- Back-to-back: following cycle `data_in`=129'h0_4278b840fb44aaa757c1bf04acbe1a3e -> `data` updated, `r_ready` stays 1; then `read`=0 -> `r_ready`=0 next cycle, `data`/`key` held, state IDLE.
- Session restart: from IDLE, `read`=1 with 129'h0_FFEEDDCCBBAA99887766554433221100 -> `key` equals it without the macro. With `RCU_KEY_LOCK_EN`, `data` equals it, `key` is unchanged and `r_ready`=1.
- KEY hold: after key capture, `read`=0 for 3 cycles, then `read`=1 with a data word -> `r_ready` 0 throughout the hold, then 1 with `data` loaded.
